// File: rtl/srio_nwr_gen.sv
// srio_nwr_gen: turns the clk_srio-side message stream into SRIO HELLO NWRITE packets.
// Ports: clk_srio/reset_srio_n; upstream data_in/valid_in/first_in/keep_in/last_in
//   with srio_length_in and nwr_req_in, ready_out; ireq_* AXI-S to the core; err_len_out.
module srio_nwr_gen #(
    parameter logic [33:0] BASE_ADDR  = 34'h0,
    parameter logic [15:0] SRC_ID     = 16'h0001,
    parameter logic [15:0] DEST_ID    = 16'h00FF,
    parameter int          MAX_BYTES  = 256,
    parameter int          SKID_DEPTH = 4
) (
    input  logic        clk_srio,
    input  logic        reset_srio_n,
    input  logic        nwr_req_in,
    input  logic [15:0] srio_length_in,
    input  logic [63:0] data_in,
    input  logic        valid_in,
    input  logic        first_in,
    input  logic [7:0]  keep_in,
    input  logic        last_in,
    output logic        ready_out,
    output logic        ireq_tvalid,
    input  logic        ireq_tready,
    output logic [63:0] ireq_tdata,
    output logic [7:0]  ireq_tkeep,
    output logic        ireq_tlast,
    output logic [31:0] ireq_tuser,
    output logic        err_len_out
);
    localparam int          PW   = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int          CW   = $clog2(SKID_DEPTH + 1);
    localparam logic [8:0]  MAXB = 9'(MAX_BYTES);
    localparam logic [15:0] MAXL = 16'(MAX_BYTES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    // Skid FIFO storage; length rides with every entry so the head is self-contained.
    logic [63:0] r_m_data  [SKID_DEPTH];
    logic [7:0]  r_m_keep  [SKID_DEPTH];
    logic [15:0] r_m_len   [SKID_DEPTH];
    logic        r_m_first [SKID_DEPTH];
    logic        r_m_last  [SKID_DEPTH];

    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic          r_rst_done;

    logic [1:0]  r_state;
    logic [15:0] r_rem;
    logic [33:0] r_addr;
    logic [7:0]  r_tid;
    logic [5:0]  r_beat;
    logic        r_err;

    logic          w_empty, w_full, w_pop, w_end_pkt, w_exh, w_tlast_d;
    logic [CW-1:0] w_free;
    logic [63:0]   w_h_data, w_hdr;
    logic [7:0]    w_h_keep;
    logic [15:0]   w_h_len;
    logic          w_h_first, w_h_last;
    logic [8:0]    w_pkt;
    logic [5:0]    w_nb_m1;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CW'(SKID_DEPTH));
    assign w_free    = CW'(SKID_DEPTH) - r_cnt;
    // One slot for the beat already in flight, one for the beat this ready requests.
    assign ready_out = reset_srio_n && r_rst_done && (w_free >= CW'(2));

    assign w_h_data  = r_m_data[r_rp];
    assign w_h_keep  = r_m_keep[r_rp];
    assign w_h_len   = r_m_len[r_rp];
    assign w_h_first = r_m_first[r_rp];
    assign w_h_last  = r_m_last[r_rp];

    assign w_pkt     = (r_rem > MAXL) ? MAXB : r_rem[8:0];
    assign w_nb_m1   = 6'((w_pkt - 9'd1) >> 3);
    assign w_end_pkt = (r_beat == w_nb_m1);
    assign w_exh     = w_end_pkt && (r_rem == {7'd0, w_pkt});
    assign w_tlast_d = w_end_pkt || w_h_last;

    assign w_hdr = {r_tid, 4'h5, 4'h4, 1'b0, 2'b01, 1'b0,
                    8'(w_pkt - 9'd1), 2'b00, r_addr};

    assign ireq_tuser  = {SRC_ID, DEST_ID};
    assign err_len_out = r_err;

    always_comb begin
        ireq_tvalid = 1'b0;
        ireq_tdata  = 64'd0;
        ireq_tkeep  = 8'd0;
        ireq_tlast  = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: w_pop = !w_empty && !(w_h_first && w_h_len != 16'd0);
            S_HDR: begin
                ireq_tvalid = 1'b1;
                ireq_tdata  = w_hdr;
                ireq_tkeep  = 8'hFF;
            end
            S_DATA: begin
                ireq_tvalid = !w_empty;
                ireq_tdata  = w_h_data;
                ireq_tkeep  = w_h_keep;
                ireq_tlast  = w_tlast_d;
                w_pop       = !w_empty && ireq_tready;
            end
            default: w_pop = !w_empty;
        endcase
    end

    always_ff @(posedge clk_srio) begin
        if (valid_in) begin
            r_m_data[r_wp]  <= data_in;
            r_m_keep[r_wp]  <= keep_in;
            r_m_len[r_wp]   <= srio_length_in;
            r_m_first[r_wp] <= first_in;
            r_m_last[r_wp]  <= last_in;
        end
    end

    always_ff @(posedge clk_srio) begin
        if (!reset_srio_n) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (valid_in)
                r_wp <= (r_wp == PW'(SKID_DEPTH - 1)) ? '0 : r_wp + PW'(1);
            if (w_pop)
                r_rp <= (r_rp == PW'(SKID_DEPTH - 1)) ? '0 : r_rp + PW'(1);
            if (valid_in && !w_pop)
                r_cnt <= r_cnt + CW'(1);
            else if (!valid_in && w_pop)
                r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk_srio) begin
        if (!reset_srio_n) begin
            r_state <= S_IDLE;
            r_rem   <= 16'd0;
            r_addr  <= 34'd0;
            r_tid   <= 8'd0;
            r_beat  <= 6'd0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        if (w_h_first && w_h_len != 16'd0) begin
                            r_rem   <= w_h_len;
                            r_addr  <= BASE_ADDR;
                            r_state <= S_HDR;
                        end else begin
                            r_err <= 1'b1;
                            if (!w_h_last)
                                r_state <= S_DROP;
                        end
                    end
                end
                S_HDR: begin
                    if (ireq_tready) begin
                        r_state <= S_DATA;
                        r_beat  <= 6'd0;
                        r_tid   <= r_tid + 8'd1;
                    end
                end
                S_DATA: begin
                    if (!w_empty && ireq_tready) begin
                        r_beat <= r_beat + 6'd1;
                        if (w_tlast_d) begin
                            if (w_h_last) begin
                                // Short message: framing ended before length ran out.
                                r_state <= S_IDLE;
                                r_err   <= !w_exh;
                            end else if (w_exh) begin
                                // Long message: length ran out, discard the tail.
                                r_err   <= 1'b1;
                                r_state <= S_DROP;
                            end else begin
                                r_rem   <= r_rem - {7'd0, w_pkt};
                                r_addr  <= r_addr + 34'(MAX_BYTES);
                                r_state <= S_HDR;
                            end
                        end
                    end
                end
                default: begin
                    if (!w_empty && w_h_last)
                        r_state <= S_IDLE;
                end
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk_srio) disable iff (!reset_srio_n)
        !(valid_in && w_full));

    logic w_unused;
    assign w_unused = nwr_req_in;
endmodule
